layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_seq_pkg.sv | 58 +++++
 rtl/layer_seq_addr_calc.sv | 43 ++++
 rtl/layer_sequencer.sv | 174 +++++++++++++++++
 tb/tb_layer_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_seq_pkg.sv
// Shared types for the layer sequencer: FSM states, address-calc steps,
// descriptor layout, cfg_field codes and descriptor field positions.
package layer_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC_F,
        S_CALC_B,
        S_CALC_O,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } seq_state_e;

    typedef enum logic [1:0] {
        STEP_F,
        STEP_B,
        STEP_O
    } calc_step_e;

    typedef struct packed {
        logic [31:0] op_config;
        logic [31:0] mapping_param;
        logic [31:0] shape_param1;
        logic [31:0] shape_param2;
    } layer_desc_t;

    localparam logic [1:0] CFG_OP_CONFIG = 2'd0;
    localparam logic [1:0] CFG_MAPPING   = 2'd1;
    localparam logic [1:0] CFG_SHAPE1    = 2'd2;
    localparam logic [1:0] CFG_SHAPE2    = 2'd3;

    // mapping_param
    localparam int E_LSB   = 12;
    localparam int E_W     = 6;
    localparam int P_LSB   = 9;
    localparam int Q_LSB   = 6;
    localparam int R_LSB   = 3;
    localparam int T_LSB   = 0;
    localparam int PQRT_W  = 3;
    // shape_param1
    localparam int STRIDE_LSB = 24;
    localparam int STRIDE_W   = 2;
    localparam int FROW_LSB   = 22;
    localparam int FCOL_LSB   = 20;
    localparam int FILT_W     = 2;
    // shape_param2
    localparam int ICOL_LSB = 0;
    localparam int ICOL_W   = 8;
    // op_config
    localparam int BIAS_SEL_BIT = 1;

    function automatic logic [31:0] get_field(input logic [31:0] v, input int lsb, input int w);
        return (v >> lsb) & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/layer_seq_addr_calc.sv
// Combinational base-address step: one of filter/bias/opsum base from the
// previous base and the current descriptor. All math wraps at ADDR_W.
module layer_addr_calc
    import layer_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  calc_step_e        step,
    input  logic [31:0]       mapping_param,
    input  logic [31:0]       shape_param1,
    input  logic [31:0]       shape_param2,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] addr
);
    logic [ADDR_W-1:0] e, p, q, r, t, stride, frow, fcol, icol;
    logic [ADDR_W-1:0] ifmap_span, filt_span, bias_span;

    assign e      = ADDR_W'(get_field(mapping_param, E_LSB, E_W));
    assign p      = ADDR_W'(get_field(mapping_param, P_LSB, PQRT_W));
    assign q      = ADDR_W'(get_field(mapping_param, Q_LSB, PQRT_W));
    assign r      = ADDR_W'(get_field(mapping_param, R_LSB, PQRT_W));
    assign t      = ADDR_W'(get_field(mapping_param, T_LSB, PQRT_W));
    assign stride = ADDR_W'(get_field(shape_param1, STRIDE_LSB, STRIDE_W));
    assign frow   = ADDR_W'(get_field(shape_param1, FROW_LSB, FILT_W));
    assign fcol   = ADDR_W'(get_field(shape_param1, FCOL_LSB, FILT_W));
    assign icol   = ADDR_W'(get_field(shape_param2, ICOL_LSB, ICOL_W));

    // e = 0 makes (e-1) wrap; that is intentional, the result simply wraps too
    assign ifmap_span = q * r * (stride * (e - ADDR_W'(1)) + frow) * icol;
    assign filt_span  = p * t * q * r * frow * fcol;
    assign bias_span  = p * t * ADDR_W'(4);

    always_comb begin
        addr = base;
        case (step)
            STEP_F:  addr = base + ifmap_span;
            STEP_B:  addr = base + filt_span;
            STEP_O:  addr = base + bias_span;
            default: addr = base;
        endcase
    end

endmodule

// File: rtl/layer_sequencer.sv
// Walks a table of layer descriptors, derives per-layer buffer base addresses
// and launches one pass per layer, waiting for the pass controller in between.
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter  int NUM_LAYERS = 8,
    parameter  int ADDR_W     = 32,
    localparam int IW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_idx,
    input  logic [1:0]        cfg_field,
    input  logic [31:0]       cfg_wdata,
    input  logic [IW:0]       num_layers,
    input  logic              start,
    input  logic              abort,
    input  logic              pass_done,
    output logic              pass_start,
    output logic [31:0]       op_config,
    output logic [31:0]       mapping_param,
    output logic [31:0]       shape_param1,
    output logic [31:0]       shape_param2,
    output logic [ADDR_W-1:0] ifmap_baseaddr,
    output logic [ADDR_W-1:0] filter_baseaddr,
    output logic [ADDR_W-1:0] bias_baseaddr,
    output logic [ADDR_W-1:0] opsum_baseaddr,
    output logic              bias_ipsum_sel,
    output logic [IW-1:0]     layer_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [IW:0] NL_MAX = (IW+1)'(NUM_LAYERS);

    seq_state_e        state, state_nxt;
    layer_desc_t       desc_mem [NUM_LAYERS];
    layer_desc_t       cur_q;
    logic [IW:0]       nl_q;
    logic [IW-1:0]     idx_q;
    logic              err_q;
    logic [ADDR_W-1:0] ifmap_q, filter_q, bias_q, opsum_q;
    calc_step_e        step;
    logic [ADDR_W-1:0] calc_base, calc_addr;
    logic              is_idle, start_ok, last_layer, stride_zero, abort_busy;

    assign is_idle     = (state == S_IDLE);
    assign abort_busy  = abort && !is_idle;
    assign start_ok    = start && is_idle && (num_layers <= NL_MAX);
    assign last_layer  = ({1'b0, idx_q} == nl_q - (IW+1)'(1));
    assign stride_zero = (get_field(desc_mem[idx_q].shape_param1, STRIDE_LSB, STRIDE_W) == 32'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_layers == '0)          state_nxt = S_FINISH;
                    else if (num_layers <= NL_MAX) state_nxt = S_LOAD;
                end
            end
            S_LOAD:   state_nxt = stride_zero ? S_FINISH : S_CALC_F;
            S_CALC_F: state_nxt = S_CALC_B;
            S_CALC_B: state_nxt = S_CALC_O;
            S_CALC_O: state_nxt = S_ISSUE;
            S_ISSUE:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (pass_done) state_nxt = last_layer ? S_FINISH : S_LOAD;
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort_busy) state_nxt = S_IDLE;
    end

    // descriptor table is only writable while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_LAYERS; i++) desc_mem[i] <= '0;
        end else if (cfg_we && is_idle && (32'(cfg_idx) < NUM_LAYERS)) begin
            case (cfg_field)
                CFG_OP_CONFIG: desc_mem[cfg_idx].op_config     <= cfg_wdata;
                CFG_MAPPING:   desc_mem[cfg_idx].mapping_param <= cfg_wdata;
                CFG_SHAPE1:    desc_mem[cfg_idx].shape_param1  <= cfg_wdata;
                default:       desc_mem[cfg_idx].shape_param2  <= cfg_wdata;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= '0;
            nl_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (start_ok) begin
                idx_q <= '0;
                nl_q  <= num_layers;
            end else if (abort_busy) begin
                idx_q <= '0;
            end else if (state == S_WAIT && pass_done && !last_layer) begin
                idx_q <= idx_q + IW'(1);
            end

            if (start && is_idle)
                err_q <= (num_layers > NL_MAX);
            else if ((cfg_we && !is_idle) || (state == S_LOAD && stride_zero && !abort))
                err_q <= 1'b1;
        end
    end

    always_comb begin
        step      = STEP_F;
        calc_base = ifmap_q;
        case (state)
            S_CALC_B: begin step = STEP_B; calc_base = filter_q; end
            S_CALC_O: begin step = STEP_O; calc_base = bias_q;   end
            default:  ;
        endcase
    end

    layer_addr_calc #(.ADDR_W(ADDR_W)) u_addr_calc (
        .step          (step),
        .mapping_param (cur_q.mapping_param),
        .shape_param1  (cur_q.shape_param1),
        .shape_param2  (cur_q.shape_param2),
        .base          (calc_base),
        .addr          (calc_addr)
    );

    // outputs only move in LOAD/CALC_*, so they hold from ISSUE to the next LOAD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_q    <= '0;
            ifmap_q  <= '0;
            filter_q <= '0;
            bias_q   <= '0;
            opsum_q  <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    cur_q   <= desc_mem[idx_q];
                    ifmap_q <= (idx_q == '0) ? '0 : opsum_q;
                end
                S_CALC_F: filter_q <= calc_addr;
                S_CALC_B: bias_q   <= calc_addr;
                S_CALC_O: opsum_q  <= calc_addr;
                default:  ;
            endcase
        end
    end

    assign pass_start      = (state == S_ISSUE);
    assign done            = (state == S_FINISH);
    assign busy            = !is_idle;
    assign layer_idx       = idx_q;
    assign err             = err_q;
    assign op_config       = cur_q.op_config;
    assign mapping_param   = cur_q.mapping_param;
    assign shape_param1    = cur_q.shape_param1;
    assign shape_param2    = cur_q.shape_param2;
    assign bias_ipsum_sel  = cur_q.op_config[BIAS_SEL_BIT];
    assign ifmap_baseaddr  = ifmap_q;
    assign filter_baseaddr = filter_q;
    assign bias_baseaddr   = bias_q;
    assign opsum_baseaddr  = opsum_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: directed literal cases plus randomized runs
// checked every cycle against a cycle-count model of the sequencer.
module tb_layer_sequencer;
    localparam int NL = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [1:0]  cfg_field = '0;
    logic [31:0] cfg_wdata = '0;
    logic [3:0]  num_layers = '0;
    logic        start = 1'b0, abort = 1'b0, pass_done = 1'b0;
    logic        pass_start, bias_ipsum_sel, busy, done, err;
    logic [31:0] op_config, mapping_param, shape_param1, shape_param2;
    logic [31:0] ifmap_baseaddr, filter_baseaddr, bias_baseaddr, opsum_baseaddr;
    logic [2:0]  layer_idx;

    layer_sequencer #(.NUM_LAYERS(NL), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_field(cfg_field),
        .cfg_wdata(cfg_wdata), .num_layers(num_layers), .start(start), .abort(abort),
        .pass_done(pass_done), .pass_start(pass_start), .op_config(op_config),
        .mapping_param(mapping_param), .shape_param1(shape_param1), .shape_param2(shape_param2),
        .ifmap_baseaddr(ifmap_baseaddr), .filter_baseaddr(filter_baseaddr),
        .bias_baseaddr(bias_baseaddr), .opsum_baseaddr(opsum_baseaddr),
        .bias_ipsum_sel(bias_ipsum_sel), .layer_idx(layer_idx), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int ps_count = 0, done_count = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [31:0] fld(input logic [31:0] v, input int lsb, input int w);
        return (v >> lsb) & ((32'd1 << w) - 32'd1);
    endfunction

    // ---------------- reference model ----------------
    // m_cnt counts cycles since the layer's load: 0 load, 1..3 address steps,
    // 4 launch, 5 waiting for pass_done.
    logic [31:0] md [NL][4];
    bit          m_busy = 0, m_fin = 0, m_err = 0;
    int          m_cnt = 0, m_layer = 0, m_nl = 0;
    logic [31:0] m_op = 0, m_map = 0, m_s1 = 0, m_s2 = 0;
    logic [31:0] m_ifm = 0, m_fil = 0, m_bia = 0, m_ops = 0;
    logic [31:0] e, p, q, r, t, st, fr, fc, ic;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NL; i++) for (int j = 0; j < 4; j++) md[i][j] = 32'd0;
            m_busy = 0; m_fin = 0; m_err = 0; m_cnt = 0; m_layer = 0; m_nl = 0;
            m_op = 0; m_map = 0; m_s1 = 0; m_s2 = 0;
            m_ifm = 0; m_fil = 0; m_bia = 0; m_ops = 0;
        end else begin
            e  = fld(m_map, 12, 6); p = fld(m_map, 9, 3); q = fld(m_map, 6, 3);
            r  = fld(m_map, 3, 3);  t = fld(m_map, 0, 3);
            st = fld(m_s1, 24, 2);  fr = fld(m_s1, 22, 2); fc = fld(m_s1, 20, 2);
            ic = fld(m_s2, 0, 8);
            if (m_busy && !m_fin) begin
                case (m_cnt)
                    0: begin
                        m_op = md[m_layer][0]; m_map = md[m_layer][1];
                        m_s1 = md[m_layer][2]; m_s2 = md[m_layer][3];
                        m_ifm = (m_layer == 0) ? 32'd0 : m_ops;
                    end
                    1: m_fil = m_ifm + q * r * (st * (e - 32'd1) + fr) * ic;
                    2: m_bia = m_fil + p * t * q * r * fr * fc;
                    3: m_ops = m_bia + p * t * 32'd4;
                    default: ;
                endcase
            end
            if (cfg_we) begin
                if (m_busy) m_err = 1;
                else md[cfg_idx][cfg_field] = cfg_wdata;
            end
            if (m_busy && abort) begin
                m_busy = 0; m_fin = 0; m_layer = 0;
            end else if (m_fin) begin
                m_fin = 0; m_busy = 0;
            end else if (m_busy) begin
                if (m_cnt == 0 && fld(md[m_layer][2], 24, 2) == 32'd0) begin
                    m_err = 1; m_fin = 1;
                end else if (m_cnt < 5) begin
                    m_cnt++;
                end else if (pass_done) begin
                    if (m_layer == m_nl - 1) m_fin = 1;
                    else begin m_layer++; m_cnt = 0; end
                end
            end else if (start) begin
                if (int'(num_layers) > NL) m_err = 1;
                else begin
                    m_err = 0; m_nl = int'(num_layers); m_layer = 0; m_cnt = 0;
                    m_busy = 1; m_fin = (num_layers == 4'd0);
                end
            end
        end
    end

    // compare process: every falling edge
    always @(negedge clk) begin
        if (pass_start) ps_count++;
        if (done) done_count++;
        chk("busy",       64'(busy),            64'(m_busy));
        chk("pass_start", 64'(pass_start),      64'(m_busy && !m_fin && m_cnt == 4));
        chk("done",       64'(done),            64'(m_fin));
        chk("err",        64'(err),             64'(m_err));
        chk("layer_idx",  64'(layer_idx),       64'(m_layer));
        chk("op_config",  64'(op_config),       64'(m_op));
        chk("mapping",    64'(mapping_param),   64'(m_map));
        chk("shape1",     64'(shape_param1),    64'(m_s1));
        chk("shape2",     64'(shape_param2),    64'(m_s2));
        chk("bias_sel",   64'(bias_ipsum_sel),  64'(m_op[1]));
        chk("ifmap",      64'(ifmap_baseaddr),  64'(m_ifm));
        chk("filter",     64'(filter_baseaddr), 64'(m_fil));
        chk("bias",       64'(bias_baseaddr),   64'(m_bia));
        chk("opsum",      64'(opsum_baseaddr),  64'(m_ops));
    end

    // ---------------- stimulus ----------------
    localparam logic [31:0] MAP = 32'h0000_4249;  // e=4 p=q=r=t=1
    localparam logic [31:0] S1  = 32'h01F0_0000;  // stride 1, filter 3x3
    localparam logic [31:0] S2  = 32'd6;          // ifmap_col 6

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input int idx, input int f, input logic [31:0] d);
        cfg_idx = 3'(idx); cfg_field = 2'(f); cfg_wdata = d; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wr_desc(input int idx, input logic [31:0] op, input logic [31:0] mp,
                           input logic [31:0] s1, input logic [31:0] s2);
        wr(idx, 0, op); wr(idx, 1, mp); wr(idx, 2, s1); wr(idx, 3, s2);
    endtask

    task automatic kick(input int nl);
        num_layers = 4'(nl); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_ps(output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!pass_start && cyc < 40);
        if (!pass_start) chk("pass_start_timeout", 64'(pass_start), 64'd1);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!done && cyc < 40);
        if (!done) chk("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic finish_pass();
        tick(); pass_done = 1'b1;
        tick(); pass_done = 1'b0;
    endtask

    initial begin
        int cyc, ps0, d0;
        logic [31:0] s1r;
        #1;
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_filter", 64'(filter_baseaddr), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        wr_desc(0, 32'h2, MAP, S1, S2);
        wr_desc(1, 32'h2, MAP, S1, S2);

        // single layer
        kick(1);
        wait_ps(cyc);
        chk("t1_ps_cycle", 64'(cyc), 64'd5);
        chk("t1_ifmap",  64'(ifmap_baseaddr),  64'd0);
        chk("t1_filter", 64'(filter_baseaddr), 64'd36);
        chk("t1_bias",   64'(bias_baseaddr),   64'd45);
        chk("t1_opsum",  64'(opsum_baseaddr),  64'd49);
        finish_pass();
        @(negedge clk);
        chk("t1_done", 64'(done), 64'd1);
        tick();

        // two layers
        ps0 = ps_count; d0 = done_count;
        kick(2);
        wait_ps(cyc);
        finish_pass();
        wait_ps(cyc);
        chk("t2_ps_cycle", 64'(cyc), 64'd5);
        chk("t2_idx",    64'(layer_idx),       64'd1);
        chk("t2_ifmap",  64'(ifmap_baseaddr),  64'd49);
        chk("t2_filter", 64'(filter_baseaddr), 64'd85);
        chk("t2_bias",   64'(bias_baseaddr),   64'd94);
        chk("t2_opsum",  64'(opsum_baseaddr),  64'd98);
        finish_pass();
        @(negedge clk);
        chk("t2_done", 64'(done), 64'd1);
        tick();
        chk("t2_ps_pulses",   64'(ps_count - ps0),   64'd2);
        chk("t2_done_pulses", 64'(done_count - d0),  64'd1);

        // zero and oversize layer counts
        ps0 = ps_count;
        kick(0);
        @(negedge clk);
        chk("nl0_done", 64'(done), 64'd1);
        tick(); tick();
        chk("nl0_no_ps", 64'(ps_count - ps0), 64'd0);
        kick(9);
        @(negedge clk);
        chk("nl9_err",  64'(err),  64'd1);
        chk("nl9_busy", 64'(busy), 64'd0);
        tick();

        // abort together with pass_done on the second layer
        kick(2);
        wait_ps(cyc);
        finish_pass();
        wait_ps(cyc);
        tick();
        d0 = done_count;
        abort = 1'b1; pass_done = 1'b1;
        tick();
        abort = 1'b0; pass_done = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy),      64'd0);
        chk("abort_idx",  64'(layer_idx), 64'd0);
        chk("abort_done", 64'(done),      64'd0);
        repeat (3) tick();
        chk("abort_no_done", 64'(done_count - d0), 64'd0);

        // cfg write and start while waiting
        kick(1);
        wait_ps(cyc);
        tick();
        cfg_idx = 3'd0; cfg_field = 2'd0; cfg_wdata = 32'h0; cfg_we = 1'b1;
        start = 1'b1; num_layers = 4'd3;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("busywr_err",  64'(err),  64'd1);
        chk("busywr_busy", 64'(busy), 64'd1);
        finish_pass();
        @(negedge clk);
        chk("busywr_done", 64'(done), 64'd1);
        tick();
        kick(1);
        @(negedge clk);
        chk("start_clears_err", 64'(err), 64'd0);
        wait_ps(cyc);
        chk("slot_unchanged", 64'(op_config), 64'h2);
        chk("bias_sel_1",     64'(bias_ipsum_sel), 64'd1);
        finish_pass();
        tick();

        // stride 0 layer
        wr(0, 2, 32'h00F0_0000);
        ps0 = ps_count;
        kick(1);
        wait_done(cyc);
        chk("s0_done_cycle", 64'(cyc), 64'd2);
        chk("s0_err", 64'(err), 64'd1);
        tick();
        chk("s0_no_ps", 64'(ps_count - ps0), 64'd0);

        // reset in CALC_B
        wr(0, 2, S1);
        kick(1);
        tick(); tick();
        #2 rst = 1'b0;
        #1;
        chk("rstmid_busy",   64'(busy),            64'd0);
        chk("rstmid_filter", 64'(filter_baseaddr), 64'd0);
        chk("rstmid_ifmap",  64'(ifmap_baseaddr),  64'd0);
        chk("rstmid_map",    64'(mapping_param),   64'd0);
        chk("rstmid_misc",   64'({pass_start, done, err, bias_ipsum_sel, layer_idx}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        wr_desc(0, 32'h0, MAP, S1, S2);
        kick(1);
        wait_ps(cyc);
        chk("rerun_ps_cycle", 64'(cyc), 64'd5);
        chk("rerun_idx",    64'(layer_idx),       64'd0);
        chk("rerun_filter", 64'(filter_baseaddr), 64'd36);
        chk("rerun_opsum",  64'(opsum_baseaddr),  64'd49);
        finish_pass();
        tick();

        // randomized runs
        for (int run = 0; run < 40; run++) begin
            for (int s = 0; s < NL; s++) begin
                if ($urandom_range(0, 1) == 1) begin
                    s1r = $urandom;
                    if ($urandom_range(0, 9) != 0 && s1r[25:24] == 2'd0) s1r[24] = 1'b1;
                    wr_desc(s, $urandom, $urandom & 32'h0003_FFFF, s1r, $urandom);
                end
            end
            kick(($urandom_range(0, 10) == 0) ? 9 : $urandom_range(0, 8));
            for (int c = 0; c < 400 && m_busy; c++) begin
                pass_done  = ($urandom_range(0, 3) == 0);
                abort      = ($urandom_range(0, 80) == 0);
                cfg_we     = ($urandom_range(0, 25) == 0);
                cfg_idx    = 3'($urandom_range(0, 7));
                cfg_field  = 2'($urandom_range(0, 3));
                cfg_wdata  = $urandom;
                start      = ($urandom_range(0, 20) == 0);
                num_layers = 4'($urandom_range(0, 9));
                tick();
            end
            pass_done = 1'b0; abort = 1'b0; cfg_we = 1'b0; start = 1'b0;
            tick();
            @(negedge clk);
            chk("rand_run_ends", 64'(busy), 64'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
